// File: rtl/ps2_pkg.sv
// Shared constants, event layout and frame-FSM encoding for the PS/2 receive path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ps2_pkg;

    // Prefix bytes that modify the following scan code
    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    // evt_data field positions
    localparam int EVT_W        = 10;
    localparam int EVT_EXT_BIT  = 9;
    localparam int EVT_BRK_BIT  = 8;
    localparam int EVT_CODE_MSB = 7;
    localparam int EVT_CODE_LSB = 0;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } evt_t;

    // Frame FSM encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    // PS/2 uses odd parity over the 8 data bits plus the parity bit
    function automatic logic odd_weight(input logic [8:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronises one asynchronous PS/2 line and debounces it with a run-length filter.
// Latency: 2 + FILTER_LEN clk cycles from pin change to line_filt change.
// Backpressure: none; free-running.
// Ports: clk, rst_n (async active-low), line_in (async pin), line_filt (filtered, resets to 1).
module ps2_line_filter #(
    parameter int FILTER_LEN = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_in,
    output logic line_filt
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] run_cnt;

    // run_cnt counts consecutive samples that disagree with the filtered value;
    // any agreeing sample restarts the run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            line_filt <= 1'b1;
            run_cnt   <= '0;
        end else begin
            sync1 <= line_in;
            sync2 <= sync1;
            if (sync2 == line_filt) begin
                run_cnt <= '0;
            end else if (run_cnt == CW'(FILTER_LEN - 1)) begin
                line_filt <= sync2;
                run_cnt   <= '0;
            end else begin
                run_cnt <= run_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: filtered sampling, frame checking, key-event decode, event FIFO.
// Latency: stop-bit fall in T -> byte_done/frame_err in T+1 -> evt_valid in T+2 (empty FIFO).
// Backpressure: valid/ready pop; when full without a pop the new event is dropped and overflow pulses.
// Ports: clk, rst_n; kb_clk/kb_data (async pins); evt_valid/evt_ready/evt_data (pop side);
//        fifo_level, frame_err, overflow, err_count (status).
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 20,
    parameter int TIMEOUT_CYC = 50000,
    parameter int FIFO_DEPTH  = 8,
    parameter int MODE        = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          kb_clk,
    input  logic                          kb_data,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [EVT_W-1:0]              evt_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          frame_err,
    output logic                          overflow,
    output logic [7:0]                    err_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    // ---------------- line conditioning ----------------
    logic clk_f, data_f, clk_f_q, fall;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk(clk), .rst_n(rst_n), .line_in(kb_clk), .line_filt(clk_f)
    );
    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
        .clk(clk), .rst_n(rst_n), .line_in(kb_data), .line_filt(data_f)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) clk_f_q <= 1'b1;
        else        clk_f_q <= clk_f;
    end

    assign fall = clk_f_q & ~clk_f;

    // ---------------- frame FSM ----------------
    logic [1:0]    state;
    logic [2:0]    bitcnt;
    logic [7:0]    shreg;
    logic          par;
    logic [TW-1:0] to_cnt;
    logic          byte_done;
    logic [7:0]    byte_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            bitcnt    <= '0;
            shreg     <= '0;
            par       <= 1'b0;
            to_cnt    <= '0;
            byte_done <= 1'b0;
            byte_q    <= '0;
            frame_err <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            frame_err <= 1'b0;
            if (fall) begin
                to_cnt <= '0;
                case (state)
                    ST_IDLE: begin
                        // A fall with data high cannot be a start bit
                        if (!data_f) begin
                            state  <= ST_DATA;
                            bitcnt <= '0;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        shreg  <= {data_f, shreg[7:1]};
                        bitcnt <= bitcnt + 1'b1;
                        if (bitcnt == 3'd7) state <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        par   <= data_f;
                        state <= ST_STOP;
                    end
                    default: begin
                        if (odd_weight({par, shreg}) && data_f) begin
                            byte_done <= 1'b1;
                            byte_q    <= shreg;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end
                endcase
            end else if (state != ST_IDLE) begin
                // Keyboard stopped clocking mid-frame: drop the partial byte
                if (to_cnt == TW'(TIMEOUT_CYC - 1)) begin
                    state     <= ST_IDLE;
                    frame_err <= 1'b1;
                    to_cnt    <= '0;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end else begin
                to_cnt <= '0;
            end
        end
    end

    // ---------------- decoder ----------------
    logic ext_q, brk_q, push;
    evt_t push_evt;

    always_comb begin
        push_evt.ext  = ext_q;
        push_evt.brk  = brk_q;
        push_evt.code = byte_q;
        push          = byte_done && (byte_q != PS2_EXT) && (byte_q != PS2_BRK);
        if (MODE == 0) begin
            push_evt.ext = 1'b0;
            push_evt.brk = 1'b0;
            push         = byte_done;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
        end else if (frame_err) begin
            // A broken frame may have eaten a prefix's partner; start clean
            ext_q <= 1'b0;
            brk_q <= 1'b0;
        end else if (byte_done) begin
            if (byte_q == PS2_EXT) begin
                ext_q <= 1'b1;
            end else if (byte_q == PS2_BRK) begin
                brk_q <= 1'b1;
            end else begin
                ext_q <= 1'b0;
                brk_q <= 1'b0;
            end
        end
    end

    // ---------------- event FIFO ----------------
    evt_t        mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, level;
    logic        full, pop, wr_en;

    assign level = wr_ptr - rd_ptr;
    assign full  = (level == (AW+1)'(FIFO_DEPTH));
    assign pop   = evt_valid && evt_ready;
    // A pop in the same cycle frees the slot the push needs
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            overflow <= push && full && !pop;
            if (wr_en) begin
                mem[wr_ptr[AW-1:0]] <= push_evt;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign evt_valid  = (wr_ptr != rd_ptr);
    assign evt_data   = mem[rd_ptr[AW-1:0]];
    assign fifo_level = level;

    // ---------------- error counter ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             err_count <= '0;
        else if (frame_err && err_count != 8'hFF) err_count <= err_count + 1'b1;
    end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: one MODE 1 and one MODE 0 instance share the pins.
// Latency: n/a.
// Backpressure: evt_ready driven per test on the MODE 1 instance; MODE 0 always ready.
module tb_ps2_rx_fifo;

    localparam int FL   = 4;
    localparam int TO   = 300;
    localparam int FD   = 4;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       kb_clk = 1'b1;
    logic       kb_data = 1'b1;
    logic       rdy1 = 1'b1;
    logic       rdy0 = 1'b1;

    logic       v1, fe1, ov1, v0, fe0, ov0;
    logic [9:0] d1, d0;
    logic [2:0] lvl1, lvl0;
    logic [7:0] ec1, ec0;

    always #5 clk = ~clk;

    ps2_rx_fifo #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO), .FIFO_DEPTH(FD), .MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .kb_clk(kb_clk), .kb_data(kb_data),
        .evt_valid(v1), .evt_ready(rdy1), .evt_data(d1), .fifo_level(lvl1),
        .frame_err(fe1), .overflow(ov1), .err_count(ec1)
    );

    ps2_rx_fifo #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO), .FIFO_DEPTH(FD), .MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .kb_clk(kb_clk), .kb_data(kb_data),
        .evt_valid(v0), .evt_ready(rdy0), .evt_data(d0), .fifo_level(lvl0),
        .frame_err(fe0), .overflow(ov0), .err_count(ec0)
    );

    int         n_chk = 0;
    int         n_fail = 0;
    logic [9:0] q1[$];
    logic [9:0] q0[$];
    int         fe_hi1 = 0;
    int         fe_rise1 = 0;
    int         ov_hi1 = 0;
    logic       fe_prev1 = 1'b0;

    // Popped-event logger and pulse counters, sampled mid-cycle
    always @(negedge clk) begin
        if (v1 && rdy1) q1.push_back(d1);
        if (v0 && rdy0) q0.push_back(d0);
        if (fe1) fe_hi1 <= fe_hi1 + 1;
        if (fe1 && !fe_prev1) fe_rise1 <= fe_rise1 + 1;
        fe_prev1 <= fe1;
        if (ov1) ov_hi1 <= ov_hi1 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        kb_data = b;
        tick(HALF);
        kb_clk = 1'b0;
        tick(HALF);
        kb_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic p, input logic stp);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(p);
        send_bit(stp);
        kb_data = 1'b1;
        tick(HALF);
    endtask

    task automatic good(input logic [7:0] b);
        send_frame(b, ~^b, 1'b1);
    endtask

    int         e_base;
    logic [7:0] code;

    initial begin
        // ---- reset state ----
        tick(5);
        chk("rst_valid", v1, 0);
        chk("rst_data", d1, 0);
        chk("rst_level", lvl1, 0);
        chk("rst_frame_err", fe1, 0);
        chk("rst_overflow", ov1, 0);
        chk("rst_err_count", ec1, 0);
        rst_n = 1'b1;
        tick(5);

        // ---- make code 0x1C ----
        rdy1 = 1'b0;
        q1.delete(); q0.delete();
        good(8'h1C);
        tick(10);
        chk("make_level", lvl1, 1);
        chk("make_valid", v1, 1);
        chk("make_head", d1, 10'h01C);
        rdy1 = 1'b1;
        tick(5);
        chk("make_n", q1.size(), 1);
        if (q1.size() > 0) chk("make_evt", q1[0], 10'h01C);
        chk("make_level_drained", lvl1, 0);
        chk("make_m0_evt", (q0.size() > 0) ? q0[0] : 10'h3FF, 10'h01C);

        // ---- break, MODE 1 and MODE 0 ----
        q1.delete(); q0.delete();
        good(8'hF0);
        good(8'h1C);
        tick(10);
        chk("brk_n", q1.size(), 1);
        if (q1.size() > 0) chk("brk_evt", q1[0], 10'h11C);
        chk("brk_m0_n", q0.size(), 2);
        if (q0.size() > 1) begin
            chk("brk_m0_evt0", q0[0], 10'h0F0);
            chk("brk_m0_evt1", q0[1], 10'h01C);
        end

        // ---- extended break ----
        q1.delete(); q0.delete();
        good(8'hE0);
        good(8'hF0);
        good(8'h75);
        tick(10);
        chk("extbrk_n", q1.size(), 1);
        if (q1.size() > 0) chk("extbrk_evt", q1[0], 10'h375);

        // ---- bad parity ----
        q1.delete(); q0.delete();
        e_base = fe_rise1;
        send_frame(8'h1C, 1'b1, 1'b1);
        tick(10);
        chk("par_n", q1.size(), 0);
        chk("par_err_pulse", fe_rise1 - e_base, 1);
        chk("par_err_count", ec1, 1);
        chk("par_m0_err_count", ec0, 1);
        good(8'h1C);
        tick(10);
        chk("par_next_n", q1.size(), 1);
        if (q1.size() > 0) chk("par_next_evt", q1[0], 10'h01C);

        // ---- timeout after 4 data bits ----
        q1.delete(); q0.delete();
        e_base = fe_rise1;
        code = 8'h2A;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(code[i]);
        kb_data = 1'b1;
        tick(TO + 50);
        chk("to_err_pulse", fe_rise1 - e_base, 1);
        chk("to_err_count", ec1, 2);
        chk("to_n", q1.size(), 0);
        good(8'h2A);
        tick(10);
        chk("to_next_n", q1.size(), 1);
        if (q1.size() > 0) chk("to_next_evt", q1[0], 10'h02A);
        chk("to_next_err_count", ec1, 2);

        // ---- overflow ----
        rdy1 = 1'b0;
        q1.delete(); q0.delete();
        e_base = ov_hi1;
        for (int i = 0; i <= FD; i++) good(8'h11 + 8'(i));
        tick(10);
        chk("ovf_level", lvl1, FD);
        chk("ovf_pulse", ov_hi1 - e_base, 1);
        chk("ovf_head", d1, 10'h011);
        rdy1 = 1'b1;
        tick(10);
        chk("ovf_drain_n", q1.size(), FD);
        for (int i = 0; i < FD; i++)
            if (q1.size() > i) chk("ovf_order", q1[i], 10'h011 + 10'(i));
        chk("ovf_level_drained", lvl1, 0);
        chk("ovf_m0_n", q0.size(), FD + 1);

        // ---- reset mid-frame ----
        q1.delete(); q0.delete();
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        kb_data = 1'b1;
        rst_n = 1'b0;
        tick(3);
        chk("mid_rst_valid", v1, 0);
        chk("mid_rst_level", lvl1, 0);
        chk("mid_rst_err_count", ec1, 0);
        chk("mid_rst_data", d1, 0);
        rst_n = 1'b1;
        tick(5);
        e_base = fe_rise1;
        good(8'h1C);
        tick(10);
        chk("mid_rst_n", q1.size(), 1);
        if (q1.size() > 0) chk("mid_rst_evt", q1[0], 10'h01C);
        chk("mid_rst_no_err", fe_rise1 - e_base, 0);
        chk("mid_rst_err_count_after", ec1, 0);

        // ---- pulse widths over the whole run ----
        chk("err_pulses_total", fe_rise1, 2);
        chk("err_pulse_width", fe_hi1, fe_rise1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

Parametrised, fully synchronous PS/2 keyboard receiver. It replaces edge-clocked frame capture with system-clock sampling, and adds odd-parity, stop-bit and inter-edge timeout checking. Received bytes are optionally decoded into make/break/extended key events and buffered in a FIFO with a valid/ready pop interface. It sits between the keyboard pins and the keycode consumers (display/ASCII logic); repeat filtering is left to the consumer.

## Interface
- `FILTER_LEN`, default 20: consecutive equal samples needed before a filtered line changes.
- `TIMEOUT_CYC`, default 50000: max `clk` cycles between falling edges inside a frame.
- `FIFO_DEPTH`, default 8: event FIFO depth; power of two, ≥2.
- `MODE`, default 1: 0 = raw bytes; 1 = decoded key events.
- `clk` in 1: system clock; one clock domain, all logic on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `kb_clk` in 1: PS/2 clock, asynchronous.
- `kb_data` in 1: PS/2 data, asynchronous.
- `evt_valid` out 1: FIFO head valid.
- `evt_ready` in 1: consumer accepts head.
- `evt_data` out 10: [9] ext, [8] brk, [7:0] code. In MODE 0, [9:8] = 0.
- `fifo_level` out clog2(FIFO_DEPTH)+1: entries held.
- `frame_err` out 1: one-cycle pulse on parity, start, stop or timeout error.
- `overflow` out 1: one-cycle pulse when an event is dropped.
- `err_count` out 8: frame errors, saturating at 255.

## Operation
- **Reset values:** all outputs 0; filtered lines 1; FSM IDLE; ext/brk flags 0; FIFO empty.
- **Line conditioning:** each line passes a 2-flop synchroniser, then a counter filter. The filtered value takes the synchronised value after FILTER_LEN consecutive equal samples. `fall` is a one-cycle strobe when filtered `kb_clk` goes 1→0.
- **Frame FSM** (all transitions only on `fall`, except timeout):
  - IDLE: data 0 → DATA with bitcnt = 0. Data 1 → stay IDLE, assert `frame_err`.
  - DATA: shift data in LSB first. After the 8th bit → PARITY.
  - PARITY: capture the parity bit → STOP.
  - STOP: if data bits plus parity have odd weight and stop = 1, strobe `byte_done` with the byte. Otherwise assert `frame_err`. Both cases → IDLE.
- **Timeout:** a counter clears on every `fall`. In any non-IDLE state, reaching TIMEOUT_CYC aborts to IDLE, pulses `frame_err` and discards the partial byte.
- **Decoder, MODE 1:**
  - 0xE0 sets ext; 0xF0 sets brk.
  - Any other byte pushes {ext, brk, byte} and clears both flags.
  - Any `frame_err` clears both flags.
  - 0xE1 is treated as an ordinary code.
- **Decoder, MODE 0:** every good byte is pushed.
- **FIFO:** show-ahead with registered head. Pop = `evt_valid && evt_ready`.
  - Push while full without a simultaneous pop: drop the new event and pulse `overflow`.
  - Push and pop in the same cycle while full: both occur; level unchanged.
  - Pop while empty: ignored.
- **err_count:** increments on each `frame_err`, saturating at 255.
- **Reset mid-frame:** the partial byte is lost. The FSM resumes in IDLE and resynchronises on the next start bit; a frame truncated by reset ends in a start error or timeout, never a bogus event.

## Timing
- Pin to filtered: 2 + FILTER_LEN cycles (the filter adds FILTER_LEN cycles).
- With `fall` high in cycle T for the stop bit:
  - `byte_done` or `frame_err` is high in T+1.
  - The FIFO write occurs at the end of T+1.
  - `evt_valid` rises in T+2 when the FIFO was empty.
- `fifo_level` updates in the cycle after the push or pop.
- `evt_data` is stable while `evt_valid` is high and `evt_ready` is low.
- `frame_err` and `overflow` each last exactly 1 cycle per event.

## Structure
- Package `ps2_pkg` holds:
  - constants `PS2_EXT` = 0xE0 and `PS2_BRK` = 0xF0;
  - `evt_data` field positions;
  - the FSM state encoding (IDLE, DATA, PARITY, STOP).
- Sub-module `ps2_line_filter` (synchroniser plus counter filter, 1 bit, parameter FILTER_LEN), instantiated twice.
- The FIFO is inline: memory array plus read/write pointers with an extra wrap bit.

## Test plan
- **Make code:** MODE 1, frame 0x1C with parity 0, stop 1 → exactly one event 0x01C; `fifo_level` 1.
- **Break and extended break:** F0, 1C → one event 0x11C. E0, F0, 75 → 0x375. The same F0, 1C in MODE 0 → events 0x0F0 and 0x01C.
- **Bad parity:** 0x1C with parity 1 → no push, `frame_err` pulse, `err_count` 1. A following good 0x1C → 0x01C.
- **Timeout:** stop after 4 data bits and idle TIMEOUT_CYC cycles → `frame_err`, FSM IDLE. The next frame 0x2A → 0x02A.
- **Overflow:** `evt_ready` = 0, send FIFO_DEPTH+1 distinct codes → level = FIFO_DEPTH and one `overflow` pulse. Draining returns the first FIFO_DEPTH codes in order.
- **Reset mid-frame:** assert `rst_n` = 0 after 3 data bits → all outputs 0. After release, the next full frame 0x1C → 0x01C with no spurious event.
